// File: rtl/pkt_transceiver_xy_if.sv
// ---------------------------------------------------------------------------
// pkt_transceiver_xy_if
// Bundles the queue-side and channel-side signals of the XY transmit stage.
//   mem_empty    : input queue empty
//   data_i       : head flit of the queue, {data, last, dest}
//   r_ready_in   : per-port receiver ready/ack (4 mesh ports + local)
//   mem_readed   : one-cycle pop strobe back to the queue
//   wr_ready_out : per-port flit-valid
//   data_o       : per-port flit buses, slice p = [p*BUS_SIZE +: BUS_SIZE]
// Modports: master = transceiver side, slave = queue/receiver side.
// ---------------------------------------------------------------------------
interface pkt_transceiver_xy_if #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4
);
  localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;

  logic                              mem_empty;
  logic [BUS_SIZE-1:0]               data_i;
  logic [PORTS_NUM:0]                r_ready_in;
  logic                              mem_readed;
  logic [PORTS_NUM:0]                wr_ready_out;
  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_o;

  modport master (
    input  mem_empty, data_i, r_ready_in,
    output mem_readed, wr_ready_out, data_o
  );

  modport slave (
    output mem_empty, data_i, r_ready_in,
    input  mem_readed, wr_ready_out, data_o
  );
endinterface

// File: rtl/pkt_transceiver_xy.sv
// ---------------------------------------------------------------------------
// pkt_transceiver_xy
// Switch transmit stage: pops flits from the input queue, routes each packet
// by XY dimension order on an X_SIZE x Y_SIZE mesh, and drives one of five
// output channels (X+, Y+, X-, Y-, local) with a 4-phase ready handshake.
// The route is locked from head to last flit (wormhole). A handshake that is
// not acknowledged within TIMEOUT cycles is aborted and the rest of the
// packet is drained from the queue.
// Ports:
//   clk, a_rst_n : clock (rising edge), asynchronous active-low reset
//   bus          : queue/channel interface (master modport)
//   busy         : high whenever the FSM is not idle
//   timeout_err  : one-cycle pulse when a handshake is aborted
//   flit_cnt     : flits delivered (wraps)
//   pkt_cnt      : packets delivered, counted on the acked last flit (wraps)
// Optional feature macro: TX_STATS_EN builds the traffic counters; without it
// flit_cnt and pkt_cnt are tied to zero.
// ---------------------------------------------------------------------------
module pkt_transceiver_xy #(
  parameter int         ADDR      = 0,
  parameter int         DATA_SIZE = 32,
  parameter int         ADDR_SIZE = 4,
  parameter int         X_SIZE    = 3,
  parameter int         Y_SIZE    = 3,
  parameter int         PORTS_NUM = 4,
  parameter logic [4:0] PORT_MASK = 5'b11111,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_SIZE  = 16
) (
  input  logic                clk,
  input  logic                a_rst_n,
  pkt_transceiver_xy_if.master bus,
  output logic                busy,
  output logic                timeout_err,
  output logic [CNT_SIZE-1:0] flit_cnt,
  output logic [CNT_SIZE-1:0] pkt_cnt
);
  localparam int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NODES_NUM = X_SIZE * Y_SIZE;
  localparam int MY_X      = ADDR % X_SIZE;
  localparam int MY_Y      = ADDR / X_SIZE;
  localparam int TIMER_W   = $clog2(TIMEOUT) + 1;
  // With TIMEOUT=0 this value is never compared.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, ACCEPT, DRAIN} state_t;

  state_t                            state, state_n;
  logic [2:0]                        port_r, port_n;
  logic                              last_r, last_n;
  logic [TIMER_W-1:0]                timer, timer_n;
  logic [PORTS_NUM:0]                wr_n;
  logic [BUS_SIZE*(PORTS_NUM+1)-1:0] data_o_n;
  logic                              mem_readed_n, timeout_n;
  logic                              flit_inc, pkt_inc;
  logic                              head_valid;

  // XY dimension-order route; unknown destinations and unconnected ports
  // fall back to the local port.
  function automatic logic [2:0] route(input logic [ADDR_SIZE-1:0] dest);
    int d, dx, dy;
    logic [2:0] p;
    d  = int'(dest);
    dx = d % X_SIZE;
    dy = d / X_SIZE;
    if (dx > MY_X)      p = 3'd0;
    else if (dx < MY_X) p = 3'd2;
    else if (dy > MY_Y) p = 3'd1;
    else if (dy < MY_Y) p = 3'd3;
    else                p = 3'd4;
    if (d >= NODES_NUM || !PORT_MASK[p]) p = 3'd4;
    return p;
  endfunction

  // The pop strobe is registered, so the queue only advances at the edge
  // after mem_readed is seen high. During that cycle data_i still shows the
  // flit just consumed; it must not be used again.
  assign head_valid = !bus.mem_empty && !bus.mem_readed;

  // Next-state and next-output logic; every register holds by default.
  always_comb begin
    state_n      = state;
    port_n       = port_r;
    last_n       = last_r;
    timer_n      = timer;
    wr_n         = bus.wr_ready_out;
    data_o_n     = bus.data_o;
    mem_readed_n = 1'b0;
    timeout_n    = 1'b0;
    flit_inc     = 1'b0;
    pkt_inc      = 1'b0;
    unique case (state)
      IDLE: begin
        if (head_valid) begin
          port_n  = route(bus.data_i[ADDR_SIZE-1:0]);
          state_n = SEND;
        end
      end
      SEND: begin
        // The previous handshake must be fully closed (ready back low).
        if (head_valid && !bus.r_ready_in[port_r]) begin
          data_o_n[port_r*BUS_SIZE +: BUS_SIZE] = bus.data_i;
          wr_n          = '0;
          wr_n[port_r]  = 1'b1;
          mem_readed_n  = 1'b1;
          last_n        = bus.data_i[ADDR_SIZE];
          timer_n       = '0;
          state_n       = ACCEPT;
        end
      end
      ACCEPT: begin
        // An ack on the final timer cycle still counts as delivered.
        if (bus.r_ready_in[port_r]) begin
          wr_n     = '0;
          flit_inc = 1'b1;
          if (last_r) begin
            pkt_inc = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = SEND;
          end
        end else if (TIMEOUT != 0 && timer == TIMER_LAST) begin
          wr_n      = '0;
          timeout_n = 1'b1;
          state_n   = last_r ? IDLE : DRAIN;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DRAIN: begin
        if (head_valid) begin
          mem_readed_n = 1'b1;
          if (bus.data_i[ADDR_SIZE]) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state            <= IDLE;
      port_r           <= 3'd4;
      last_r           <= 1'b0;
      timer            <= '0;
      bus.wr_ready_out <= '0;
      bus.data_o       <= '0;
      bus.mem_readed   <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      state            <= state_n;
      port_r           <= port_n;
      last_r           <= last_n;
      timer            <= timer_n;
      bus.wr_ready_out <= wr_n;
      bus.data_o       <= data_o_n;
      bus.mem_readed   <= mem_readed_n;
      timeout_err      <= timeout_n;
    end
  end

  assign busy = (state != IDLE);

`ifdef TX_STATS_EN
  // Traffic counters; wrap naturally at 2^CNT_SIZE.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      flit_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (flit_inc) flit_cnt <= flit_cnt + 1'b1;
      if (pkt_inc)  pkt_cnt  <= pkt_cnt + 1'b1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = flit_inc | pkt_inc;
  assign flit_cnt     = '0;
  assign pkt_cnt      = '0;
`endif
endmodule

// File: tb/tb_pkt_transceiver_xy.sv
// ---------------------------------------------------------------------------
// tb_pkt_transceiver_xy
// Bench for pkt_transceiver_xy at node 4 (x1,y1) of a 3x3 mesh. A queue
// model feeds flits, a receiver model answers the 4-phase handshake with
// programmable delay, and a scoreboard of expected {port, flit} entries is
// built from the XY routing rules. A second instance with port 0
// disconnected checks the mask fallback to the local port.
// ---------------------------------------------------------------------------
module tb_pkt_transceiver_xy;
  localparam int DATA_SIZE = 32;
  localparam int ADDR_SIZE = 4;
  localparam int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1;
  localparam int NP        = 5;
  localparam int CNT_SIZE  = 16;
  localparam int TIMEOUT   = 16;

  typedef struct {
    int                  port;
    logic [BUS_SIZE-1:0] flit;
  } exp_t;

  typedef struct {
    int dest;
    int port;
  } vec_t;

  logic clk = 1'b0;
  logic a_rst_n = 1'b0;
  logic busy, timeout_err, busy_m, timeout_err_m;
  logic [CNT_SIZE-1:0] flit_cnt, pkt_cnt, flit_cnt_m, pkt_cnt_m;

  pkt_transceiver_xy_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .PORTS_NUM(4)) bus ();
  pkt_transceiver_xy_if #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .PORTS_NUM(4)) bus_m ();

  pkt_transceiver_xy #(
    .ADDR(4), .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .X_SIZE(3), .Y_SIZE(3),
    .PORTS_NUM(4), .PORT_MASK(5'b11111), .TIMEOUT(TIMEOUT), .CNT_SIZE(CNT_SIZE)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus), .busy(busy),
    .timeout_err(timeout_err), .flit_cnt(flit_cnt), .pkt_cnt(pkt_cnt)
  );

  pkt_transceiver_xy #(
    .ADDR(4), .DATA_SIZE(DATA_SIZE), .ADDR_SIZE(ADDR_SIZE), .X_SIZE(3), .Y_SIZE(3),
    .PORTS_NUM(4), .PORT_MASK(5'b11110), .TIMEOUT(TIMEOUT), .CNT_SIZE(CNT_SIZE)
  ) dut_m (
    .clk(clk), .a_rst_n(a_rst_n), .bus(bus_m), .busy(busy_m),
    .timeout_err(timeout_err_m), .flit_cnt(flit_cnt_m), .pkt_cnt(pkt_cnt_m)
  );

  always #5 clk = ~clk;

  // Queue, scoreboard and receiver model state.
  logic [BUS_SIZE-1:0] q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_flits = 0;
  int   exp_pkts = 0;
  int   ack_delay[NP];
  int   wait_cnt[NP];
  bit   hold_ready[NP];
  int   hi_cycles[NP];
  bit   rand_delay = 0;
  int   acks_left = -1;
  int   to_pulses = 0;
  int   mr_pulses = 0;
  logic to_prev = 1'b0;

  // Guards against a hung DUT or bench.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // XY rules for node (1,1) of a 3x3 mesh.
  function automatic int refRoute(input int dest, input logic [4:0] mask);
    int cx, cy, p;
    if (dest >= 9) return 4;
    cx = dest % 3;
    cy = dest / 3;
    if (cx == 2)      p = 0;
    else if (cx == 0) p = 2;
    else if (cy == 2) p = 1;
    else if (cy == 0) p = 3;
    else              p = 4;
    return mask[p] ? p : 4;
  endfunction

  function automatic logic [BUS_SIZE-1:0] makeFlit(input logic [31:0] d, input logic last,
                                                   input int dest);
    logic [3:0] dst;
    dst = dest[3:0];
    return {d, last, dst};
  endfunction

  task automatic driveQueue();
    bus.mem_empty = (q.size() == 0);
    if (q.size() > 0) bus.data_i = q[0];
    else              bus.data_i = '0;
  endtask

  // Queue a packet; the first 'issued' flits are expected on 'port'.
  task automatic pushPacket(input int head_dest, input int nflits, input int body_dest,
                            input int issued, input int port);
    logic [BUS_SIZE-1:0] f;
    exp_t e;
    for (int i = 0; i < nflits; i++) begin
      f = makeFlit($urandom, (i == nflits - 1), (i == 0) ? head_dest : body_dest);
      q.push_back(f);
      if (i < issued) begin
        e.port = port;
        e.flit = f;
        exp_q.push_back(e);
      end
    end
    driveQueue();
  endtask

  // One clock: queue pop, output monitoring, receiver response.
  task automatic applyStimulus();
    bit pop;
    logic [NP-1:0] wr_prev;
    exp_t e;
    pop     = bus.mem_readed;
    wr_prev = bus.wr_ready_out;
    @(posedge clk);
    #1;
    if (pop && q.size() > 0) void'(q.pop_front());
    driveQueue();
    checkOutput("wr_onehot", ($countones(bus.wr_ready_out) <= 1), 1);
    for (int p = 0; p < NP; p++) begin
      if (bus.wr_ready_out[p] && !wr_prev[p]) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_flit", bus.wr_ready_out, '0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("flit_port", p, e.port);
          checkOutput("flit_data", bus.data_o[p*BUS_SIZE +: BUS_SIZE], e.flit);
        end
      end
      if (bus.wr_ready_out[p]) hi_cycles[p]++;
    end
    if (timeout_err) begin
      to_pulses++;
      if (to_prev) checkOutput("timeout_err_width", 2, 1);
    end
    to_prev = timeout_err;
    if (bus.mem_readed) mr_pulses++;
    for (int p = 0; p < NP; p++) begin
      if (hold_ready[p]) begin
        bus.r_ready_in[p] = 1'b1;
      end else if (bus.wr_ready_out[p]) begin
        wait_cnt[p]++;
        if (!bus.r_ready_in[p] && wait_cnt[p] > ack_delay[p] && acks_left != 0) begin
          bus.r_ready_in[p] = 1'b1;
          if (acks_left > 0) acks_left--;
        end
      end else begin
        bus.r_ready_in[p] = 1'b0;
        wait_cnt[p] = 0;
        if (rand_delay) ack_delay[p] = $urandom_range(0, 4);
      end
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      applyStimulus();
      n++;
      done = (q.size() == 0) && !busy && (exp_q.size() == 0) && !bus.mem_readed;
    end
    checkOutput(name, done, 1);
  endtask

  task automatic checkCounters(input string tag);
`ifdef TX_STATS_EN
    checkOutput({tag, "_flit_cnt"}, flit_cnt, exp_flits);
    checkOutput({tag, "_pkt_cnt"}, pkt_cnt, exp_pkts);
`else
    checkOutput({tag, "_flit_cnt"}, flit_cnt, 0);
    checkOutput({tag, "_pkt_cnt"}, pkt_cnt, 0);
`endif
  endtask

  task automatic clearStats();
    for (int p = 0; p < NP; p++) hi_cycles[p] = 0;
    to_pulses = 0;
    mr_pulses = 0;
  endtask

  initial begin
    vec_t vecs[10];
    logic [BUS_SIZE-1:0] mf;
    int n, nf, hd, bd;

    vecs = '{'{5, 0}, '{3, 2}, '{7, 1}, '{1, 3}, '{4, 4},
             '{12, 4}, '{0, 2}, '{8, 0}, '{2, 0}, '{15, 4}};
    for (int p = 0; p < NP; p++) begin
      ack_delay[p]  = 0;
      wait_cnt[p]   = 0;
      hold_ready[p] = 0;
    end
    clearStats();
    bus.r_ready_in   = '0;
    bus_m.r_ready_in = '0;
    bus_m.mem_empty  = 1'b1;
    bus_m.data_i     = '0;
    driveQueue();

    // Reset state.
    a_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_wr_ready_out", bus.wr_ready_out, '0);
    checkOutput("rst_data_o", bus.data_o, '0);
    checkOutput("rst_mem_readed", bus.mem_readed, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkCounters("rst");
    @(negedge clk);
    a_rst_n = 1'b1;
    applyStimulus();
    applyStimulus();

    // Routing table: single-flit packets, prompt ack.
    for (int i = 0; i < 10; i++) begin
      clearStats();
      pushPacket(vecs[i].dest, 1, 0, 1, vecs[i].port);
      waitIdle(40, "vec_done");
      checkOutput("vec_port_active", hi_cycles[vecs[i].port], 1);
      checkOutput("vec_mem_readed", mr_pulses, 1);
      exp_flits++;
      exp_pkts++;
    end
    checkCounters("vec");

    // 3-flit wormhole packet: body dest ignored, all flits on Y- (port 3).
    clearStats();
    pushPacket(1, 3, 7, 3, 3);
    waitIdle(60, "worm_done");
    checkOutput("worm_mem_readed", mr_pulses, 3);
    checkOutput("worm_port3_cycles", hi_cycles[3], 3);
    checkOutput("worm_port1_cycles", hi_cycles[1], 0);
    exp_flits += 3;
    exp_pkts++;
    checkCounters("worm");

    // Receiver ready stuck high blocks issue until it drops.
    clearStats();
    hold_ready[0] = 1;
    pushPacket(5, 1, 0, 1, 0);
    repeat (8) applyStimulus();
    checkOutput("held_no_issue", bus.wr_ready_out, '0);
    checkOutput("held_no_pop", q.size(), 1);
    hold_ready[0] = 0;
    waitIdle(40, "held_done");
    exp_flits++;
    exp_pkts++;
    checkCounters("held");

    // Ack seen on the last timer cycle: delivered, no abort.
    clearStats();
    ack_delay[0] = TIMEOUT - 1;
    pushPacket(5, 1, 0, 1, 0);
    waitIdle(60, "edge_done");
    checkOutput("edge_no_timeout", to_pulses, 0);
    checkOutput("edge_valid_cycles", hi_cycles[0], TIMEOUT);
    ack_delay[0] = 0;
    exp_flits++;
    exp_pkts++;
    checkCounters("edge");

    // Timeout on flit 2 of 4: abort, drain flits 3-4 silently.
    clearStats();
    acks_left = 1;
    pushPacket(5, 4, 0, 2, 0);
    waitIdle(100, "tmo_done");
    checkOutput("tmo_pulses", to_pulses, 1);
    checkOutput("tmo_valid_cycles", hi_cycles[0], 1 + TIMEOUT);
    checkOutput("tmo_mem_readed", mr_pulses, 4);
    acks_left = -1;
    exp_flits++;
    checkCounters("tmo");

    // Randomized traffic against the routing model.
    clearStats();
    rand_delay = 1;
    for (int k = 0; k < 25; k++) begin
      nf = $urandom_range(1, 4);
      hd = $urandom_range(0, 15);
      bd = $urandom_range(0, 15);
      pushPacket(hd, nf, bd, nf, refRoute(hd, 5'b11111));
      exp_flits += nf;
      exp_pkts++;
    end
    waitIdle(4000, "rand_done");
    checkOutput("rand_no_timeout", to_pulses, 0);
    rand_delay = 0;
    for (int p = 0; p < NP; p++) ack_delay[p] = 0;
    checkCounters("rand");

    // Asynchronous reset while a flit waits for ack.
    acks_left = 0;
    pushPacket(5, 2, 0, 1, 0);
    n = 0;
    while (bus.wr_ready_out == '0 && n < 10) begin
      applyStimulus();
      n++;
    end
    checkOutput("arst_in_accept", (bus.wr_ready_out != '0), 1);
    #2;
    a_rst_n = 1'b0;
    #1;
    checkOutput("arst_wr_ready_out", bus.wr_ready_out, '0);
    checkOutput("arst_data_o", bus.data_o, '0);
    checkOutput("arst_mem_readed", bus.mem_readed, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_timeout_err", timeout_err, 0);
    checkOutput("arst_flit_cnt", flit_cnt, 0);
    checkOutput("arst_pkt_cnt", pkt_cnt, 0);
    q.delete();
    exp_q.delete();
    driveQueue();
    bus.r_ready_in = '0;
    acks_left = -1;
    exp_flits = 0;
    exp_pkts = 0;
    @(negedge clk);
    a_rst_n = 1'b1;

    // Masked instance: port 0 unconnected, dest 5 falls back to local.
    mf = makeFlit(32'hA5A5_0001, 1'b1, 5);
    bus_m.data_i = mf;
    bus_m.mem_empty = 1'b0;
    n = 0;
    while (bus_m.wr_ready_out == '0 && n < 8) begin
      @(posedge clk);
      #1;
      if (bus_m.mem_readed) bus_m.mem_empty = 1'b1;
      n++;
    end
    checkOutput("mask_wr_ready_out", bus_m.wr_ready_out, 5'b10000);
    checkOutput("mask_data_local", bus_m.data_o[4*BUS_SIZE +: BUS_SIZE], mf);
    bus_m.r_ready_in = 5'b10000;
    @(posedge clk);
    #1;
    checkOutput("mask_ack_clears", bus_m.wr_ready_out, '0);
    bus_m.r_ready_in = '0;
    @(posedge clk);
    #1;
    checkOutput("mask_idle", busy_m, 0);
    checkOutput("post_rst_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
